// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - load/store unit: address gen, alignment check, lane steering, memory handshake
// One access in flight at a time; every accepted instruction yields exactly one out_valid pulse.
module ysyx_24100005_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [1:0]  out_err
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_REQ    = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_RESP   = 2'd3;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  ea_lo_q, ea_lo_d;
  logic        is_store_q, is_store_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_err_q, out_err_d;

  logic [31:0] ea;
  logic        is_load, is_store, f3_ok, misal, acc_err;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [15:0] cnt_inc;
  logic        timed_out;

  assign in_ready = (state_q == S_IDLE) & rst;
  assign ea       = rs1_val + imm;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misal   = ((funct3[1:0] == 2'b01) & ea[0]) |
                   ((funct3[1:0] == 2'b10) & (ea[1:0] != 2'b00));
  assign acc_err = (is_load | is_store) & (~f3_ok | misal);

  // Store data is replicated across lanes so the strobe alone selects the bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_val[7:0]}};
        st_wstrb = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_val[15:0]}};
        st_wstrb = 4'b0011 << ea[1:0];
      end
      default: begin
        st_wdata = rs2_val;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign ld_byte = mem_rdata[{ea_lo_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{ea_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign cnt_inc   = cnt_q + 16'd1;
  assign timed_out = (cnt_inc == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    ea_lo_d     = ea_lo_q;
    is_store_d  = is_store_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    out_valid_d = 1'b0;
    out_data_d  = 32'h0;
    out_err_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (in_valid & in_ready) begin
          cnt_d      = 16'h0;
          funct3_d   = funct3;
          ea_lo_d    = ea[1:0];
          is_store_d = is_store;
          if ((is_load | is_store) & ~acc_err) begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_wen_d   = is_store;
            mem_addr_d  = {ea[31:2], 2'b00};
            mem_wdata_d = is_store ? st_wdata : 32'h0;
            mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
          end else begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_err_d   = {1'b0, acc_err};
          end
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_inc;
        // Completion in the final allowed cycle takes precedence over the timeout.
        if (mem_rvalid & (mem_gnt | (state_q == S_WAIT))) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = is_store_q ? 32'h0 : ld_data;
        end else if (timed_out) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_err_d   = 2'b10;
        end else if ((state_q == S_REQ) & mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'h0;
      funct3_q    <= 3'b000;
      ea_lo_q     <= 2'b00;
      is_store_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      ea_lo_q     <= ea_lo_d;
      is_store_q  <= is_store_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// tb/tb_ysyx_24100005_lsu.sv - scoreboard bench for ysyx_24100005_lsu with randomized and directed accesses
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = 7'h0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] rs1_val = 32'h0;
  logic [31:0] rs2_val = 32'h0;
  logic [31:0] imm = 32'h0;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = 32'h0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
    logic [31:0] cyc;
  } exp_t;
  exp_t exp_q[$];

  ysyx_24100005_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_out_valid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_err", {30'h0, out_err}, {30'h0, e.err});
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  // g: cycle index of mem_gnt after accept; r: extra cycles until mem_rvalid (0 = same cycle).
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] im, input int g, input int r,
                       input logic [31:0] rdata);
    logic [31:0] ea, exp_data, exp_wdata, v;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_err;
    logic        is_ld, is_st, legal, mis, memop;
    int size, k, last, wait_n, sh;
    logic [31:0] acc;
    exp_t e;

    wait_n = 0;
    @(negedge clk);
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", {31'h0, in_ready}, 32'd1);
      return;
    end
    opcode = opc; funct3 = f3; rs1_val = rs1; rs2_val = rs2; imm = im;
    mem_rdata = rdata; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    opcode = 7'h7f; rs1_val = $urandom; imm = $urandom; rs2_val = $urandom;

    is_ld = (opc == 7'h03);
    is_st = (opc == 7'h23);
    ea    = rs1 + im;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = ((ea & 32'(size - 1)) != 32'h0);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    memop = (is_ld || is_st) && legal && !mis;
    exp_err = {1'b0, (is_ld || is_st) && !(legal && !mis)};

    if (!memop) begin
      e.data = 32'h0; e.err = exp_err; e.cyc = acc;
      exp_q.push_back(e);
      chk("no_mem_req", {31'h0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
      chk("in_ready_after_resp", {31'h0, in_ready}, 32'd1);
      return;
    end

    k    = g + r;
    last = (k > 3) ? 3 : k;
    sh   = 8 * int'(ea[1:0]);
    case (f3)
      3'd0: begin v = (rdata >> sh) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = (rdata >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = (rdata >> sh) & 32'hFF;
      3'd5: v = (rdata >> sh) & 32'hFFFF;
      default: v = rdata;
    endcase
    exp_data = is_st ? 32'h0 : v;
    if (k > 3) begin
      exp_data = 32'h0;
      exp_err  = 2'b10;
    end
    case (size)
      1: begin exp_wdata = (rs2 & 32'hFF) * 32'h01010101;   exp_strb = 4'(1 << ea[1:0]); end
      2: begin exp_wdata = (rs2 & 32'hFFFF) * 32'h00010001; exp_strb = 4'(3 << ea[1:0]); end
      default: begin exp_wdata = rs2; exp_strb = 4'hF; end
    endcase
    if (is_ld) exp_strb = 4'h0;
    e.data = exp_data; e.err = exp_err; e.cyc = acc + 32'd1 + 32'(last);
    exp_q.push_back(e);

    for (int idx = 0; idx <= last; idx++) begin
      chk("mem_req", {31'h0, mem_req}, {31'h0, idx <= g});
      if (idx <= g) begin
        chk("mem_addr", mem_addr, ea & 32'hFFFFFFFC);
        chk("mem_wen", {31'h0, mem_wen}, {31'h0, is_st});
        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_strb});
        if (is_st) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      mem_gnt    = (idx == g);
      mem_rvalid = (idx == k);
      @(posedge clk);
      #1;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (k > 3) begin
      chk("timeout_req_drop", {31'h0, mem_req}, 32'd0);
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEADBEEF;
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk("in_ready_after_resp", {31'h0, in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] opc;
    int sel;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_mem_bus", {mem_wen, mem_wstrb, 27'h0} | mem_addr | mem_wdata, 32'h0);
    chk("rst_out", {out_valid, out_err, 29'h0} | out_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    do_op(7'h03, 3'b000, 32'h80000003, 32'h0, 32'h0, 0, 0, 32'h80FF1234);
    do_op(7'h03, 3'b101, 32'h80000000, 32'h0, 32'h2, 0, 0, 32'hBEEF0000);
    do_op(7'h03, 3'b001, 32'h80000000, 32'h0, 32'h2, 0, 0, 32'hBEEF0000);
    do_op(7'h23, 3'b000, 32'h80000001, 32'h000000A5, 32'h0, 0, 0, 32'h0);
    do_op(7'h23, 3'b010, 32'h80000004, 32'h12345678, 32'h0, 1, 1, 32'h0);
    do_op(7'h23, 3'b001, 32'h80000000, 32'h0000CAFE, 32'h2, 2, 1, 32'h0);
    do_op(7'h03, 3'b010, 32'h80000002, 32'h0, 32'h0, 0, 0, 32'h0);
    do_op(7'h03, 3'b011, 32'h80000000, 32'h0, 32'h0, 0, 0, 32'h0);
    do_op(7'h13, 3'b000, 32'h80000000, 32'h0, 32'h4, 0, 0, 32'h0);
    do_op(7'h03, 3'b010, 32'h80000008, 32'h0, 32'h0, 9, 0, 32'h11111111);
    do_op(7'h03, 3'b010, 32'h8000000C, 32'h0, 32'h0, 3, 0, 32'h76543210);

    // Reset while waiting for the read response.
    @(negedge clk);
    opcode = 7'h03; funct3 = 3'b010; rs1_val = 32'h80000010; imm = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_mid_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'd0);
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    chk("rst_hold_in_ready", {31'h0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(7'h03, 3'b010, 32'h80000010, 32'h0, 32'h0, 1, 0, 32'hA5A55A5A);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45) opc = 7'h03;
      else if (sel < 85) opc = 7'h23;
      else begin
        opc = 7'($urandom);
        if (opc == 7'h03 || opc == 7'h23) opc = 7'h13;
      end
      do_op(opc, 3'($urandom), 32'h80000000 | ($urandom & 32'hFFF), $urandom,
            32'($urandom_range(0, 15)) - 32'd8, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
# ysyx_24100005_lsu

Load/store unit for the NPC core. It sits between the decode/execute datapath and the data-memory port, and owns the full memory access: effective-address generation, alignment check, store lane/strobe formation, a request/response handshake with memory, and extraction plus sign/zero extension of load data. It sits in front of the memory-read path and returns one result per accepted instruction to write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access is aborted with a timeout error; legal range 1..65535.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk edge)
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  LSU can accept; high only in IDLE and while rst=1
- opcode  in  7  inst[6:0]
- funct3  in  3  inst[14:12]
- rs1_val  in  32  base register value
- rs2_val  in  32  store data register value
- imm  in  32  immediate, already sign-extended by decode
- mem_req  out  1  memory request, held until granted
- mem_wen  out  1  1 = store, 0 = load; valid while mem_req=1
- mem_addr  out  32  word-aligned address ({ea[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write strobes; 0 for loads
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response/ack; mem_rdata valid for loads
- mem_rdata  in  32  aligned read word
- out_valid  out  1  one-cycle result pulse to write-back
- out_data  out  32  extended load result; 0 for stores, non-memory ops and errors
- out_err  out  2  [0] misaligned/illegal funct3, [1] timeout; valid with out_valid

## Operation
- Accept on in_valid & in_ready; latch opcode, funct3, rs2_val and ea = rs1_val + imm (mod 2^32, carry dropped).
- Load: opcode 7'b0000011, funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store: opcode 7'b0100011, funct3 000 SB, 001 SH, 010 SW.
- Any other opcode: no bus activity; RESP with out_data=0, out_err=0.
- Error check at accept: halfword with ea[0]=1, word with ea[1:0]!=0, or an unlisted funct3 sets out_err[0]. No bus request is made; go directly to RESP.
- Store lanes: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<ea[1:0]. SH wdata={2{rs2[15:0]}}, wstrb=4'b0011<<ea[1:0]. SW wdata=rs2, wstrb=4'b1111.
- Load extract: byte = mem_rdata[8*ea[1:0]+:8], half = mem_rdata[16*ea[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word. Data is captured on the mem_rvalid cycle.
- FSM:
  - IDLE: on accept, go to REQ for a legal memory op, otherwise to RESP.
  - REQ: mem_req=1. On mem_gnt go to WAIT; on mem_gnt & mem_rvalid in the same cycle go straight to RESP.
  - WAIT: on mem_rvalid go to RESP. For stores, mem_rvalid is the write ack.
  - RESP: out_valid=1 for exactly one cycle, then IDLE.
- Timeout: a 16-bit counter clears on accept and increments each cycle in REQ/WAIT. At count == TIMEOUT_CYCLES without completion: drop mem_req, go to RESP with out_err[1]=1, out_data=0.
- mem_rvalid/mem_gnt in IDLE or RESP are ignored. A late response after a timeout is discarded.

## Timing
- Reset (rst=0 at an edge): state=IDLE, counter=0. mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb, out_valid, out_data and out_err are all 0; in_ready=0 while rst=0.
- All outputs except in_ready are registered; in_ready = (state==IDLE) & rst.
- Accept at edge N:
  - mem_req high from cycle N+1.
  - Best case (gnt and rvalid both in cycle N+1): out_valid in cycle N+2, in_ready high again in N+3.
  - Error or non-memory op: out_valid in cycle N+1, in_ready high again in N+2.
- mem_addr, mem_wen, mem_wdata and mem_wstrb stay stable for as long as mem_req=1.
- Reset mid-operation returns to IDLE at the next edge with mem_req=0. No out_valid is produced for the aborted instruction.
- Throughput: at most one outstanding access; no new accept until after RESP.

## Test plan
- LB ea=0x80000003, mem_rdata=0x80FF1234 -> mem_addr=0x80000000, mem_wstrb=0; out_data=0xFFFFFF80, out_err=0, out_valid at N+2 when gnt=rvalid=1 in N+1.
- LHU rs1=0x80000000, imm=2, mem_rdata=0xBEEF0000 -> out_data=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- SB rs2=0x000000A5, ea=0x80000001 -> mem_wen=1, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b0010; SW ea=0x80000004 -> wstrb=4'b1111; out_data=0.
- LW ea=0x80000002 -> mem_req never asserts, out_valid at N+1 with out_err=2'b01; same for funct3=3'b011 load.
- TIMEOUT_CYCLES=4, mem_gnt held 0 -> mem_req high for 4 cycles then 0, out_err=2'b10, out_data=0; an rvalid pulse injected afterwards is ignored.
- Reset (rst=0) while in WAIT -> next edge: mem_req=0, in_ready stays 0 while rst=0; after release, a fresh LW completes normally with no stale out_valid.
